param_mode_counter: RTL and testbench

- Parametrised multi-mode counter; next generation of the team's single-width counter design.
- Adds configurable width, modulo bound, step size, up/down/load modes, wrap-or-saturate policy, a terminal-count pulse and a sticky overflow flag.
- Sits directly under the pattern/testbench harness, with the same clk_p / rst_n / data_in / data_out connection style, plus control inputs.

---
 rtl/param_mode_counter.sv | 102 ++++++++++
 tb/tb_param_mode_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/param_mode_counter.sv
// Parametrised up/down/load counter with modulo bound, wrap-or-saturate policy,
// terminal-count pulse, load range error pulse and sticky overflow flag.
module param_mode_counter #(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 255,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic              ovf,
  output logic              load_err
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MOD_MAX);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MOD_MAX);
  // MOD_MAX+1 may equal 2^WIDTH and truncate to zero; the wrapped results are
  // always below 2^WIDTH, so modulo-2^WIDTH arithmetic still yields them exactly.
  localparam logic [WIDTH-1:0] SPAN_W = WIDTH'(MOD_MAX + 1);

  mode_t            mode_sel;
  logic [WIDTH-1:0] step_w;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             lerr_nxt;

  assign mode_sel = mode_t'(mode);
  assign step_w   = WIDTH'(step);
  assign sum_x    = {1'b0, data_out} + {1'b0, step_w};
  assign wrap_up  = sum_x[WIDTH-1:0] - SPAN_W;
  assign wrap_dn  = data_out - step_w + SPAN_W;

  always_comb begin
    cnt_nxt  = data_out;
    tc_nxt   = 1'b0;
    lerr_nxt = 1'b0;
    if (en) begin
      case (mode_sel)
        MODE_HOLD: cnt_nxt = data_out;
        MODE_UP: begin
          if (sum_x > MAX_X) begin
            tc_nxt  = 1'b1;
            cnt_nxt = (SATURATE != 0) ? MAX_W : wrap_up;
          end else begin
            cnt_nxt = sum_x[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          if (data_out >= step_w) begin
            cnt_nxt = data_out - step_w;
          end else begin
            tc_nxt  = 1'b1;
            cnt_nxt = (SATURATE != 0) ? '0 : wrap_dn;
          end
        end
        MODE_LOAD: begin
          if (data_in > MAX_W) begin
            lerr_nxt = 1'b1;
            cnt_nxt  = MAX_W;
          end else begin
            cnt_nxt  = data_in;
          end
        end
        default: cnt_nxt = data_out;
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= WIDTH'(RST_VAL);
      tc       <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      data_out <= cnt_nxt;
      tc       <= tc_nxt;
      load_err <= lerr_nxt;
      // a new boundary event outranks a simultaneous clear
      ovf      <= tc_nxt | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_param_mode_counter.sv
// Bench for param_mode_counter: wrap and saturate instances (MOD_MAX=9, RST_VAL=5)
// plus a full-range 4-bit instance, driven by a vector table, corner sequences and random stimulus.
module tb_param_mode_counter;

  logic       clk_p;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] step;
  logic [7:0] din;
  logic       clr;

  logic [7:0] q_w, q_s;
  logic [3:0] q_n;
  logic       tc_w, ovf_w, le_w;
  logic       tc_s, ovf_s, le_s;
  logic       tc_n, ovf_n, le_n;

  int n_checks = 0;
  int n_fail   = 0;

  param_mode_counter #(.WIDTH(8), .MOD_MAX(9), .STEP_W(4), .SATURATE(0), .RST_VAL(5)) u_wrap (
    .clk_p(clk_p), .rst_n(rst_n), .en(en), .mode(mode), .step(step), .data_in(din),
    .clr_ovf(clr), .data_out(q_w), .tc(tc_w), .ovf(ovf_w), .load_err(le_w)
  );

  param_mode_counter #(.WIDTH(8), .MOD_MAX(9), .STEP_W(4), .SATURATE(1), .RST_VAL(5)) u_sat (
    .clk_p(clk_p), .rst_n(rst_n), .en(en), .mode(mode), .step(step), .data_in(din),
    .clr_ovf(clr), .data_out(q_s), .tc(tc_s), .ovf(ovf_s), .load_err(le_s)
  );

  param_mode_counter #(.WIDTH(4), .MOD_MAX(15), .STEP_W(4), .SATURATE(0), .RST_VAL(0)) u_narrow (
    .clk_p(clk_p), .rst_n(rst_n), .en(en), .mode(mode), .step(step), .data_in(din[3:0]),
    .clr_ovf(clr), .data_out(q_n), .tc(tc_n), .ovf(ovf_n), .load_err(le_n)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int en; int mode; int step; int din; int clr;
    int qw; int tcw; int ovfw;
    int qs; int tcs; int ovfs;
    int le;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int e, input int md, input int st, input int di, input int c);
    en   = 1'(e);
    mode = 2'(md);
    step = 4'(st);
    din  = 8'(di);
    clr  = 1'(c);
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  // Spec-level next-count rule on plain integers.
  function automatic void ref_next(input int cnt, input int max, input bit sat,
                                   input int e, input int md, input int st, input int di,
                                   output int nc, output int t, output int le);
    nc = cnt; t = 0; le = 0;
    if (e != 0) begin
      case (md)
        1: if (cnt + st > max) begin t = 1; nc = sat ? max : cnt + st - (max + 1); end
           else nc = cnt + st;
        2: if (cnt >= st) nc = cnt - st;
           else begin t = 1; nc = sat ? 0 : cnt + max + 1 - st; end
        3: if (di > max) begin le = 1; nc = max; end
           else nc = di;
        default: nc = cnt;
      endcase
    end
  endfunction

  initial begin
    int mw, ms, mn, ow, os, on;
    int tw, ts, tn, lw, ls, ln;
    int e, md, st, di, c;

    // en, mode, step, din, clr | wrap q,tc,ovf | sat q,tc,ovf | load_err
    vecs.push_back('{1,1,1,0,0,   6,0,0,  6,0,0, 0});
    vecs.push_back('{1,1,1,0,0,   7,0,0,  7,0,0, 0});
    vecs.push_back('{1,1,1,0,0,   8,0,0,  8,0,0, 0});
    vecs.push_back('{1,3,0,8,0,   8,0,0,  8,0,0, 0});
    vecs.push_back('{1,1,3,0,0,   1,1,1,  9,1,1, 0});
    vecs.push_back('{1,1,3,0,0,   4,0,1,  9,1,1, 0});
    vecs.push_back('{1,3,0,1,0,   1,0,1,  1,0,1, 0});
    vecs.push_back('{1,2,3,0,0,   8,1,1,  0,1,1, 0});
    vecs.push_back('{1,2,3,0,0,   5,0,1,  0,1,1, 0});
    vecs.push_back('{1,3,0,12,0,  9,0,1,  9,0,1, 1});
    vecs.push_back('{1,3,0,4,0,   4,0,1,  4,0,1, 0});
    vecs.push_back('{1,0,3,0,1,   4,0,0,  4,0,0, 0});
    vecs.push_back('{0,1,3,0,0,   4,0,0,  4,0,0, 0});
    vecs.push_back('{0,3,0,12,0,  4,0,0,  4,0,0, 0});
    vecs.push_back('{1,0,5,0,0,   4,0,0,  4,0,0, 0});
    vecs.push_back('{1,1,0,0,0,   4,0,0,  4,0,0, 0});
    vecs.push_back('{1,2,0,0,0,   4,0,0,  4,0,0, 0});
    vecs.push_back('{1,1,6,0,1,   0,1,1,  9,1,1, 0});
    vecs.push_back('{1,0,0,0,1,   0,0,0,  9,0,0, 0});
    vecs.push_back('{1,2,1,0,0,   9,1,1,  8,0,0, 0});
    vecs.push_back('{0,0,0,0,1,   9,0,0,  8,0,0, 0});

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst q_w", q_w, 5);   chk("rst q_s", q_s, 5);   chk("rst q_n", q_n, 0);
    chk("rst tc_w", tc_w, 0); chk("rst ovf_w", ovf_w, 0); chk("rst le_w", le_w, 0);
    chk("rst tc_s", tc_s, 0); chk("rst ovf_s", ovf_s, 0);
    @(negedge clk_p);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].step, vecs[i].din, vecs[i].clr);
      tick();
      chk($sformatf("row%0d q_w", i),   q_w,   vecs[i].qw);
      chk($sformatf("row%0d tc_w", i),  tc_w,  vecs[i].tcw);
      chk($sformatf("row%0d ovf_w", i), ovf_w, vecs[i].ovfw);
      chk($sformatf("row%0d le_w", i),  le_w,  vecs[i].le);
      chk($sformatf("row%0d q_s", i),   q_s,   vecs[i].qs);
      chk($sformatf("row%0d tc_s", i),  tc_s,  vecs[i].tcs);
      chk($sformatf("row%0d ovf_s", i), ovf_s, vecs[i].ovfs);
      chk($sformatf("row%0d le_s", i),  le_s,  vecs[i].le);
    end

    // Async reset mid-count with ovf and tc set, then resume counting.
    drive(1, 3, 0, 9, 0);
    tick();
    drive(1, 1, 1, 0, 0);
    tick();
    chk("pre-rst q_w", q_w, 0);  chk("pre-rst tc_w", tc_w, 1); chk("pre-rst ovf_w", ovf_w, 1);
    chk("pre-rst q_s", q_s, 9);  chk("pre-rst tc_s", tc_s, 1); chk("pre-rst ovf_s", ovf_s, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async q_w", q_w, 5);  chk("async tc_w", tc_w, 0); chk("async ovf_w", ovf_w, 0);
    chk("async q_s", q_s, 5);  chk("async tc_s", tc_s, 0); chk("async ovf_s", ovf_s, 0);
    chk("async q_n", q_n, 0);
    @(negedge clk_p);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("resume%0d q_w", k), q_w, 6 + k);
      chk($sformatf("resume%0d q_s", k), q_s, 6 + k);
      chk($sformatf("resume%0d q_n", k), q_n, 1 + k);
    end

    // Randomized phase against the integer reference model.
    @(negedge clk_p);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mw = 5; ms = 5; mn = 0; ow = 0; os = 0; on = 0;
    for (int r = 0; r < 400; r++) begin
      e  = ($urandom_range(0, 9) < 8) ? 1 : 0;
      md = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 10));
      di = int'($urandom_range(0, 15));
      c  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      drive(e, md, st, di, c);
      ref_next(mw, 9,  1'b0, e, md, st, di, mw, tw, lw);
      ref_next(ms, 9,  1'b1, e, md, st, di, ms, ts, ls);
      ref_next(mn, 15, 1'b0, e, md, st, di, mn, tn, ln);
      ow = (tw != 0 || (ow != 0 && c == 0)) ? 1 : 0;
      os = (ts != 0 || (os != 0 && c == 0)) ? 1 : 0;
      on = (tn != 0 || (on != 0 && c == 0)) ? 1 : 0;
      tick();
      chk($sformatf("rnd%0d q_w", r), q_w, mw);   chk($sformatf("rnd%0d tc_w", r), tc_w, tw);
      chk($sformatf("rnd%0d ovf_w", r), ovf_w, ow); chk($sformatf("rnd%0d le_w", r), le_w, lw);
      chk($sformatf("rnd%0d q_s", r), q_s, ms);   chk($sformatf("rnd%0d tc_s", r), tc_s, ts);
      chk($sformatf("rnd%0d ovf_s", r), ovf_s, os); chk($sformatf("rnd%0d le_s", r), le_s, ls);
      chk($sformatf("rnd%0d q_n", r), q_n, mn);   chk($sformatf("rnd%0d tc_n", r), tc_n, tn);
      chk($sformatf("rnd%0d ovf_n", r), ovf_n, on); chk($sformatf("rnd%0d le_n", r), le_n, ln);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
